// File: rtl/laser_pkg.sv
`default_nettype none
// ---- laser_pkg : shared channel state encoding and default timing constants -- rev 1.0
package laser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ON       = 2'd1,
    ST_LOCKOUT  = 2'd2,
    ST_COOLDOWN = 2'd3
  } ch_state_t;

  localparam int CLK_HZ       = 50000000;
  localparam int DEF_ON_MAX   = 150000000;
  localparam int DEF_COOLDOWN = 25000000;

endpackage
`default_nettype wire

// File: rtl/laser_channel.sv
`default_nettype none
// ---- laser_channel : one laser FSM with on-time limit, lockout, cooldown, sticky fault -- rev 1.0
module laser_channel
  import laser_pkg::*;
#(
  parameter int ON_MAX   = DEF_ON_MAX,
  parameter int COOLDOWN = DEF_COOLDOWN,
  parameter int CNT_W    = 28
) (
  input  logic clock,
  input  logic reset,
  input  logic grant,
  input  logic req_n,
  input  logic fault_clr,
  output logic laser_n,
  output logic active,
  output logic fault,
  output logic idle,
  output logic active_next
);

  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_MAX - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam bit               HAS_CD  = (COOLDOWN > 0);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             fault_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      fault <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    fault_nxt = fault & ~fault_clr;
    case (state)
      ST_IDLE: begin
        if (!req_n && grant) begin
          state_nxt = ST_ON;
          timer_nxt = '0;
        end
      end
      ST_ON: begin
        // release has priority over a timeout landing on the same edge
        if (req_n) begin
          state_nxt = HAS_CD ? ST_COOLDOWN : ST_IDLE;
          timer_nxt = '0;
        end else if (timer == ON_LAST) begin
          state_nxt = ST_LOCKOUT;
          timer_nxt = '0;
          fault_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (req_n) begin
          state_nxt = HAS_CD ? ST_COOLDOWN : ST_IDLE;
          timer_nxt = '0;
        end
      end
      ST_COOLDOWN: begin
        if (timer == CD_LAST) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  assign laser_n     = (state != ST_ON);
  assign active      = (state == ST_ON);
  assign idle        = (state == ST_IDLE);
  assign active_next = (state_nxt == ST_ON);

endmodule
`default_nettype wire

// File: rtl/laser_array_driver.sv
`default_nettype none
// ---- laser_array_driver : NUM_CH laser channels sharing a MAX_ACTIVE power budget -- rev 1.0
module laser_array_driver
  import laser_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ON_MAX     = DEF_ON_MAX,
  parameter int COOLDOWN   = DEF_COOLDOWN,
  parameter int MAX_ACTIVE = 2,
  parameter int CNT_W      = 28
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               req_n,
  input  logic                            fault_clr,
  output logic [NUM_CH-1:0]               laser_n,
  output logic [NUM_CH-1:0]               active,
  output logic [NUM_CH-1:0]               fault,
  output logic [$clog2(NUM_CH+1)-1:0]     active_count
);

  localparam int CW = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] idle;
  logic [NUM_CH-1:0] active_next;
  logic [CW-1:0]     count_next;
  int                free_slots;
  int                used_slots;

  // lowest index wins while slots remain, judged against the registered count
  always_comb begin
    grant      = '0;
    free_slots = MAX_ACTIVE - int'(active_count);
    used_slots = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idle[i] && !req_n[i] && (used_slots < free_slots)) begin
        grant[i]   = 1'b1;
        used_slots = used_slots + 1;
      end
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_next = count_next + CW'(active_next[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_count <= '0;
    end else begin
      active_count <= count_next;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    laser_channel #(
      .ON_MAX   (ON_MAX),
      .COOLDOWN (COOLDOWN),
      .CNT_W    (CNT_W)
    ) u_channel (
      .clock       (clock),
      .reset       (reset),
      .grant       (grant[g]),
      .req_n       (req_n[g]),
      .fault_clr   (fault_clr),
      .laser_n     (laser_n[g]),
      .active      (active[g]),
      .fault       (fault[g]),
      .idle        (idle[g]),
      .active_next (active_next[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_array_driver.sv
`default_nettype none
// ---- tb_laser_array_driver : directed self-checking bench, ON_MAX=8 COOLDOWN=4 MAX_ACTIVE=2 -- rev 1.0
module tb_laser_array_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       fault_clr;
  logic [3:0] laser_n;
  logic [3:0] active;
  logic [3:0] fault;
  logic [2:0] active_count;

  int total = 0;
  int bad   = 0;

  laser_array_driver #(
    .NUM_CH     (4),
    .ON_MAX     (8),
    .COOLDOWN   (4),
    .MAX_ACTIVE (2),
    .CNT_W      (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_n        (req_n),
    .fault_clr    (fault_clr),
    .laser_n      (laser_n),
    .active       (active),
    .fault        (fault),
    .active_count (active_count)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_n = 4'hF; fault_clr = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    total++; if (laser_n !== 4'hF) begin bad++; $display("FAIL reset_laser got=%b want=1111", laser_n); end
    total++; if (fault !== 4'h0) begin bad++; $display("FAIL reset_fault got=%b want=0000", fault); end
    total++; if (active_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", active_count); end
    req_n[0] = 1'b0;
    step(1);
    total++; if (laser_n !== 4'b1110) begin bad++; $display("FAIL pre_reset_fire got=%b want=1110", laser_n); end
    reset = 1'b1;
    step(1);
    total++; if (laser_n !== 4'hF) begin bad++; $display("FAIL midfire_reset_laser got=%b want=1111", laser_n); end
    total++; if (active_count !== 3'd0) begin bad++; $display("FAIL midfire_reset_count got=%0d want=0", active_count); end
    reset = 1'b0;
    step(1);
    total++; if (laser_n !== 4'b1110) begin bad++; $display("FAIL post_reset_fire got=%b want=1110", laser_n); end
    req_n[0] = 1'b1;
    step(5);
  endtask

  task automatic test_short_fire;
    req_n[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++; if (laser_n[0] !== 1'b0) begin bad++; $display("FAIL short_on[%0d] got=%b want=0", i, laser_n[0]); end
    end
    req_n[0] = 1'b1;
    step(1);
    total++; if (laser_n[0] !== 1'b1) begin bad++; $display("FAIL short_release got=%b want=1", laser_n[0]); end
    req_n[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++; if (laser_n[0] !== 1'b1) begin bad++; $display("FAIL cooldown_ignore[%0d] got=%b want=1", i, laser_n[0]); end
    end
    step(1);
    total++; if (laser_n[0] !== 1'b0) begin bad++; $display("FAIL refire_after_cd got=%b want=0", laser_n[0]); end
    req_n[0] = 1'b1;
    step(5);
  endtask

  task automatic test_timeout;
    req_n[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++;
      if (laser_n[1] !== (i >= 8)) begin bad++; $display("FAIL timeout_on[%0d] got=%b want=%b", i, laser_n[1], (i >= 8)); end
    end
    total++; if (fault !== 4'b0010) begin bad++; $display("FAIL timeout_fault got=%b want=0010", fault); end
    total++; if (active_count !== 3'd0) begin bad++; $display("FAIL timeout_count got=%0d want=0", active_count); end
    req_n[1] = 1'b1;
    step(1);
    req_n[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++; if (laser_n[1] !== 1'b1) begin bad++; $display("FAIL lockout_cd[%0d] got=%b want=1", i, laser_n[1]); end
    end
    step(1);
    total++; if (laser_n[1] !== 1'b0) begin bad++; $display("FAIL timeout_refire got=%b want=0", laser_n[1]); end
    req_n[1] = 1'b1;
    step(5);
    total++; if (fault[1] !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", fault[1]); end
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    total++; if (fault !== 4'b0000) begin bad++; $display("FAIL fault_clear got=%b want=0000", fault); end
  endtask

  task automatic test_grant;
    req_n = 4'h0;
    step(1);
    total++; if (laser_n !== 4'b1100) begin bad++; $display("FAIL grant_first got=%b want=1100", laser_n); end
    total++; if (active_count !== 3'd2) begin bad++; $display("FAIL grant_count2 got=%0d want=2", active_count); end
    req_n[0] = 1'b1;
    step(1);
    total++; if (laser_n !== 4'b1101) begin bad++; $display("FAIL grant_release got=%b want=1101", laser_n); end
    total++; if (active_count !== 3'd1) begin bad++; $display("FAIL grant_count1 got=%0d want=1", active_count); end
    step(1);
    total++; if (laser_n !== 4'b1001) begin bad++; $display("FAIL grant_ch2 got=%b want=1001", laser_n); end
    total++; if (active !== 4'b0110) begin bad++; $display("FAIL grant_active got=%b want=0110", active); end
    total++; if (active_count !== 3'd2) begin bad++; $display("FAIL grant_count_refill got=%0d want=2", active_count); end
    req_n = 4'hF;
    step(1);
    total++; if (laser_n !== 4'hF) begin bad++; $display("FAIL grant_all_off got=%b want=1111", laser_n); end
    step(5);
  endtask

  task automatic test_release_at_timeout;
    req_n[2] = 1'b0;
    step(8);
    total++; if (laser_n[2] !== 1'b0) begin bad++; $display("FAIL rel_to_on got=%b want=0", laser_n[2]); end
    req_n[2] = 1'b1;
    step(1);
    total++; if (laser_n[2] !== 1'b1) begin bad++; $display("FAIL rel_to_off got=%b want=1", laser_n[2]); end
    total++; if (fault[2] !== 1'b0) begin bad++; $display("FAIL rel_to_fault got=%b want=0", fault[2]); end
    step(5);
  endtask

  task automatic test_fault_clr_collision;
    req_n[3] = 1'b0;
    step(8);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    total++; if (fault !== 4'b1000) begin bad++; $display("FAIL set_beats_clr got=%b want=1000", fault); end
    total++; if (laser_n[3] !== 1'b1) begin bad++; $display("FAIL collide_laser got=%b want=1", laser_n[3]); end
    req_n[3] = 1'b1;
    step(5);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    total++; if (fault !== 4'b0000) begin bad++; $display("FAIL collide_clear got=%b want=0000", fault); end
  endtask

  initial begin
    reset = 1'b1; req_n = 4'hF; fault_clr = 1'b0;
    test_reset;
    test_short_fire;
    test_timeout;
    test_grant;
    test_release_at_timeout;
    test_fault_clr_collision;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/laser_array_driver.md
Name: laser_array_driver

Overview:
Multi-channel successor to the single-laser on-timer. Drives NUM_CH active-low laser outputs from active-low fire requests. Each channel has a hard on-time limit, a latched timeout fault, re-arm lockout and a post-fire cooldown. A global cap limits simultaneous lasers to MAX_ACTIVE (power budget). Sits between the game-logic trigger inputs and the laser GPIO pins.

Parameters:
NUM_CH, 4, number of laser channels
ON_MAX, 150000000, max continuous on-time in clock cycles (3 s at 50 MHz); must be >= 1
COOLDOWN, 25000000, forced-off cycles after every firing; 0 allowed
MAX_ACTIVE, 2, max channels simultaneously on; 1..NUM_CH
CNT_W, 28, per-channel timer width; must hold max(ON_MAX, COOLDOWN)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
req_n  in  NUM_CH  per-channel fire request, 0 = fire
fault_clr  in  1  single-cycle pulse, clears all fault bits
laser_n  out  NUM_CH  laser drive, 0 = on, 1 = off
active  out  NUM_CH  1 = channel currently in ON
fault  out  NUM_CH  sticky timeout flag per channel
active_count  out  $clog2(NUM_CH+1)  number of channels in ON

Behaviour:
- Reset (synchronous, active-high): all channels IDLE, timers 0, laser_n all 1, active 0, fault 0, active_count 0. Reset mid-firing turns the laser off on the next edge; there is no cooldown after reset.
- All outputs are decoded from registered state only; there are no combinational paths from req_n to laser_n.
- Per-channel FSM: IDLE, ON, LOCKOUT, COOLDOWN. laser_n = 0 only in ON.
- IDLE: if req_n == 0 and the channel is granted, go to ON with timer 0. If not granted, stay IDLE and retry every cycle while the request is held.
- Grant: computed from the registered active count. Free = MAX_ACTIVE - active_count. Requesting IDLE channels are granted in ascending index order (lowest index wins) until free slots are used up.
- Slot accounting: a channel leaving ON frees its slot the cycle after it leaves.
- ON: timer increments each cycle.
  - req_n == 1: go to COOLDOWN, timer 0.
  - Else if timer == ON_MAX-1: go to LOCKOUT and set fault[i]. The laser is on for exactly ON_MAX cycles.
  - If release and timeout happen in the same cycle, release wins: COOLDOWN, no fault.
- LOCKOUT: laser off. Wait for req_n == 1, then go to COOLDOWN with timer 0. A held trigger never re-fires.
- COOLDOWN: laser off; requests ignored. Timer counts to COOLDOWN-1, then go to IDLE. If COOLDOWN == 0, go from ON/LOCKOUT directly to IDLE.
- Latency: req_n sampled low at edge k (granted) gives laser_n low after edge k. Release sampled at edge m gives laser_n high after edge m.
- fault: set by timeout, cleared by fault_clr. If set and clear happen in the same cycle, set wins.
- Timers never wrap: they are held or reset at every terminal count.
- active_count: registered popcount of active, updated the same edge as the states.

Decomposition:
- Shared package laser_pkg:
  - channel state encoding (2-bit enum IDLE/ON/LOCKOUT/COOLDOWN)
  - default ON_MAX/COOLDOWN constants, CLK_HZ = 50000000
- Sub-module laser_channel (one per channel, generate loop): FSM, timer and fault bit. Inputs: grant, req_n, fault_clr. Outputs: laser_n, active, fault.
- Top level holds the priority grant logic and the active_count register.

Test Plan (NUM_CH=4, ON_MAX=8, COOLDOWN=4, MAX_ACTIVE=2):
- Reset asserted while ch0 is firing -> laser_n=4'b1111, fault=0, active_count=0 on the next cycle; no cooldown delay on the next request.
- ch0 req_n low for 3 cycles -> laser_n[0]=0 for exactly 3 cycles, then 4 cooldown cycles; a re-request during cooldown is ignored and fires on the 5th cycle.
- ch1 req_n held low for 20 cycles -> laser on for exactly 8 cycles, fault[1]=1, stays off. Release -> 4 cooldown cycles then IDLE. fault_clr pulse -> fault[1]=0.
- All four req_n low in the same cycle -> ch0 and ch1 on, ch2 and ch3 waiting, active_count=2. Release ch0 -> ch2 on one cycle later; ch3 still waits.
- ch2 release in the same cycle as timeout (timer=7) -> COOLDOWN, fault[2] stays 0.
- fault_clr asserted in the same cycle as ch3 times out -> fault[3]=1.
